alu_exec_stage: RTL and testbench

ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

---
 rtl/alu_exec_stage.sv | 200 ++++++++++++++++++++
 tb/tb_alu_exec_stage.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: SIMD integer execute stage with a multi-cycle multiply.
//
// Parameters
//   N        lane width in bits (default 24)
//   LANES    number of SIMD lanes (default 4); lane l is bits [N*l+N-1:N*l]
//   MUL_LAT  multiply latency in cycles, 1..15 (default 3)
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   in_valid / in_ready            operation handshake
//   rd1, rd2, rd3                  register-file operands (N*LANES)
//   Forward1, Forward2, Forward3   forwarded operands (N*LANES)
//   pc, imm                        program counter / immediate, broadcast to lanes
//   aluControl                     opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR,
//                                  5 SLL, 6 SRL, 7 MUL, 8 PASS op2, else 0
//   immSrc, branchFlag, Fa, Fb, Fc operand-select controls
//   out_valid / out_ready          result handshake
//   aluResult, RD3Out              registered lane results, selected third operand
//   flags                          per lane: bit 2l zero, bit 2l+1 negative
//   busy                           high while a multiply is in flight
//
// Build option: define ALU_EXEC_SAT_EN to make ADD/SUB saturate as signed N-bit;
// otherwise they wrap modulo 2^N.
module alu_exec_stage #(
  parameter int unsigned N       = 24,
  parameter int unsigned LANES   = 4,
  parameter int unsigned MUL_LAT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*LANES-1:0]   rd1,
  input  logic [N*LANES-1:0]   rd2,
  input  logic [N*LANES-1:0]   rd3,
  input  logic [N*LANES-1:0]   Forward1,
  input  logic [N*LANES-1:0]   Forward2,
  input  logic [N*LANES-1:0]   Forward3,
  input  logic [N-1:0]         pc,
  input  logic [N-1:0]         imm,
  input  logic [3:0]           aluControl,
  input  logic                 immSrc,
  input  logic                 branchFlag,
  input  logic                 Fa,
  input  logic                 Fb,
  input  logic                 Fc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*LANES-1:0]   aluResult,
  output logic [N*LANES-1:0]   RD3Out,
  output logic [2*LANES-1:0]   flags,
  output logic                 busy
);

  typedef enum logic {IDLE, MUL_BUSY} state_t;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_MUL  = 4'd7,
    OP_PASS = 4'd8
  } op_t;

  localparam logic [N-1:0] SMAX     = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] SMIN     = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] NW       = N[N-1:0];
  localparam logic [3:0]   CNT_INIT = 4'(MUL_LAT - 1);
  localparam bit           MUL_MULTI = (MUL_LAT > 1);

  function automatic logic [N-1:0] alu_lane(input logic [N-1:0] a,
                                            input logic [N-1:0] b,
                                            input logic [3:0]   op);
    logic [N-1:0]   r;
    logic [N-1:0]   sum;
    logic [N-1:0]   dif;
    logic [N-1:0]   sh;
    logic [2*N-1:0] prod;
    sum  = a + b;
    dif  = a - b;
    sh   = b % NW;
    prod = {{N{1'b0}}, a} * {{N{1'b0}}, b};
`ifdef ALU_EXEC_SAT_EN
    if ((a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]))
      sum = a[N-1] ? SMIN : SMAX;
    if ((a[N-1] != b[N-1]) && (dif[N-1] != a[N-1]))
      dif = a[N-1] ? SMIN : SMAX;
`endif
    r = '0;
    case (op)
      OP_ADD:  r = sum;
      OP_SUB:  r = dif;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLL:  r = a << sh;
      OP_SRL:  r = a >> sh;
      OP_MUL:  r = prod[N-1:0];
      OP_PASS: r = b;
      default: r = '0;
    endcase
    return r;
  endfunction

  state_t               state;
  logic [3:0]           cnt;
  logic [N*LANES-1:0]   op1, op2, op3;
  logic [N*LANES-1:0]   m_op1, m_op2, m_op3;
  logic [N*LANES-1:0]   src1, src2, src3;
  logic [3:0]           src_op;
  logic [N*LANES-1:0]   res;
  logic [2*LANES-1:0]   nxt_flags;
  logic                 accept;
  logic                 start_mul;
  logic                 load;

  assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
  assign busy      = (state == MUL_BUSY);
  assign accept    = in_valid && in_ready;
  assign start_mul = MUL_MULTI && (aluControl == OP_MUL);

  // Single-cycle ops (and MUL when MUL_LAT==1) load on the accepting edge;
  // multi-cycle MUL loads once the counter has drained and the output is free.
  assign load = ((state == IDLE) && accept && !start_mul) ||
                ((state == MUL_BUSY) && (cnt == '0) && (!out_valid || out_ready));

  always_comb begin
    op1 = '0;
    op2 = '0;
    op3 = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      op1[l*N +: N] = Fa ? Forward1[l*N +: N] : (branchFlag ? pc : rd1[l*N +: N]);
      op2[l*N +: N] = Fb ? Forward2[l*N +: N] : (immSrc ? imm : rd2[l*N +: N]);
      op3[l*N +: N] = Fc ? Forward3[l*N +: N] : rd3[l*N +: N];
    end
  end

  // The same lane datapath serves both paths: live operands when idle,
  // captured operands while a multiply is in flight.
  always_comb begin
    src1      = busy ? m_op1 : op1;
    src2      = busy ? m_op2 : op2;
    src3      = busy ? m_op3 : op3;
    src_op    = busy ? OP_MUL : aluControl;
    res       = '0;
    nxt_flags = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      res[l*N +: N]    = alu_lane(src1[l*N +: N], src2[l*N +: N], src_op);
      nxt_flags[2*l]   = (res[l*N +: N] == '0);
      nxt_flags[2*l+1] = res[l*N + N - 1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      aluResult <= '0;
      RD3Out    <= '0;
      flags     <= '0;
      m_op1     <= '0;
      m_op2     <= '0;
      m_op3     <= '0;
    end else begin
      if (load) begin
        aluResult <= res;
        RD3Out    <= src3;
        flags     <= nxt_flags;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (accept && start_mul) begin
            m_op1 <= op1;
            m_op2 <= op2;
            m_op3 <= op3;
            cnt   <= CNT_INIT;
            state <= MUL_BUSY;
          end
        end
        MUL_BUSY: begin
          if (cnt != '0)
            cnt <= cnt - 4'd1;
          else if (load)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [95:0] rd1, rd2, rd3;
  logic [95:0] Forward1, Forward2, Forward3;
  logic [23:0] pc, imm;
  logic [3:0]  aluControl;
  logic        immSrc, branchFlag, Fa, Fb, Fc;
  logic        out_valid;
  logic        out_ready;
  logic [95:0] aluResult, RD3Out;
  logic [7:0]  flags;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  alu_exec_stage #(.N(24), .LANES(4), .MUL_LAT(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .rd1        (rd1),
    .rd2        (rd2),
    .rd3        (rd3),
    .Forward1   (Forward1),
    .Forward2   (Forward2),
    .Forward3   (Forward3),
    .pc         (pc),
    .imm        (imm),
    .aluControl (aluControl),
    .immSrc     (immSrc),
    .branchFlag (branchFlag),
    .Fa         (Fa),
    .Fb         (Fb),
    .Fc         (Fc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .aluResult  (aluResult),
    .RD3Out     (RD3Out),
    .flags      (flags),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [95:0] rep(input logic [23:0] x);
    return {x, x, x, x};
  endfunction

  function automatic logic [95:0] pk(input logic [23:0] l3, l2, l1, l0);
    return {l3, l2, l1, l0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_ins();
    in_valid = 0; rd1 = '0; rd2 = '0; rd3 = '0;
    Forward1 = '0; Forward2 = '0; Forward3 = '0;
    pc = '0; imm = '0; aluControl = '0;
    immSrc = 0; branchFlag = 0; Fa = 0; Fb = 0; Fc = 0;
  endtask

  initial begin
    clear_ins();
    rst = 1; out_ready = 1;
    tick(); tick();
    rst = 0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", aluResult, '0);
    chk("rst_rd3", RD3Out, '0);
    chk("rst_flags", flags, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);

    // ADD with immediate
    aluControl = 4'd0; immSrc = 1; rd1 = rep(24'd5); imm = 24'd7; in_valid = 1;
    tick();
    chk("add_valid", out_valid, 1);
    chk("add_result", aluResult, rep(24'd12));
    chk("add_flags", flags, 8'h00);

    // SUB: lane0 3-3, lane1 2-3, lanes 2/3 0-0
    clear_ins();
    aluControl = 4'd1; rd1 = pk(0, 0, 2, 3); rd2 = pk(0, 0, 3, 3); rd3 = rep(24'd6); in_valid = 1;
    tick();
    chk("sub_result", aluResult, pk(0, 0, 24'hFFFFFF, 0));
    chk("sub_flags", flags, 8'h59);
    chk("sub_rd3", RD3Out, rep(24'd6));

    // MUL, latency 3, then hold with out_ready low
    clear_ins();
    aluControl = 4'd7; rd1 = pk(0, 0, 3, 1000); rd2 = pk(0, 0, 5, 2000); rd3 = rep(24'd6); in_valid = 1;
    tick();
    chk("mul_busy0", busy, 1);
    chk("mul_ready0", in_ready, 0);
    chk("mul_valid0", out_valid, 0);
    in_valid = 0; rd1 = rep(24'hABCDEF); rd2 = rep(24'h000003); out_ready = 0;
    tick();
    chk("mul_busy1", busy, 1);
    chk("mul_ready1", in_ready, 0);
    tick();
    chk("mul_busy2", busy, 1);
    chk("mul_valid2", out_valid, 0);
    tick();
    chk("mul_valid3", out_valid, 1);
    chk("mul_busy3", busy, 0);
    chk("mul_result", aluResult, pk(0, 0, 15, 24'h1E8480));
    chk("mul_flags", flags, 8'h50);
    chk("mul_rd3", RD3Out, rep(24'd6));
    chk("hold_ready0", in_ready, 0);

    // held two cycles; an offered ADD must not be taken
    aluControl = 4'd0; in_valid = 1;
    tick();
    chk("hold1_valid", out_valid, 1);
    chk("hold1_result", aluResult, pk(0, 0, 15, 24'h1E8480));
    chk("hold1_ready", in_ready, 0);
    tick();
    chk("hold2_result", aluResult, pk(0, 0, 15, 24'h1E8480));
    chk("hold2_flags", flags, 8'h50);
    in_valid = 0; out_ready = 1;
    tick();
    chk("drain_valid", out_valid, 0);

    // result presented while out_ready low, then simultaneous drain + accept
    clear_ins();
    out_ready = 0; aluControl = 4'd0; rd1 = rep(24'd5); rd2 = rep(24'd1); in_valid = 1;
    tick();
    chk("b2b_first", aluResult, rep(24'd6));
    out_ready = 1; rd1 = rep(24'd10);
    tick();
    chk("b2b_valid", out_valid, 1);
    chk("b2b_second", aluResult, rep(24'd11));

    // forwarding beats branchFlag/pc; Fc selects Forward3
    clear_ins();
    in_valid = 1; aluControl = 4'd0; Fa = 1; Forward1 = rep(24'd9); rd1 = rep(24'd1);
    branchFlag = 1; pc = 24'd77; immSrc = 1; imm = 24'd0;
    Fc = 1; Forward3 = rep(24'd4); rd3 = rep(24'd6);
    tick();
    chk("fwd_add", aluResult, rep(24'd9));
    chk("fwd_rd3", RD3Out, rep(24'd4));
    aluControl = 4'd8; Fb = 1; Forward2 = rep(24'h55);
    tick();
    chk("pass_fwd2", aluResult, rep(24'h55));
    Fa = 0; Fb = 0; Fc = 0; aluControl = 4'd0; pc = 24'd100; imm = 24'd4;
    tick();
    chk("pc_imm_add", aluResult, rep(24'd104));
    chk("rd3_unfwd", RD3Out, rep(24'd6));

    // logic ops and shifts (shift amount taken modulo 24)
    clear_ins();
    in_valid = 1; rd1 = rep(24'hF0F00F); rd2 = rep(24'h0FF0FF);
    aluControl = 4'd2; tick(); chk("and", aluResult, rep(24'h00F00F));
    aluControl = 4'd3; tick(); chk("or",  aluResult, rep(24'hFFF0FF));
    aluControl = 4'd4; tick(); chk("xor", aluResult, rep(24'hFF00F0));
    rd1 = rep(24'd1); rd2 = pk(3, 0, 24, 25);
    aluControl = 4'd5; tick(); chk("sll_mod", aluResult, pk(8, 1, 1, 2));
    rd1 = rep(24'h800000); rd2 = pk(47, 1, 23, 0);
    aluControl = 4'd6; tick(); chk("srl_mod", aluResult, pk(1, 24'h400000, 1, 24'h800000));
    aluControl = 4'd12; tick();
    chk("undef_op", aluResult, '0);
    chk("undef_flags", flags, 8'h55);

    // reset one cycle into a multiply abandons it
    clear_ins();
    aluControl = 4'd7; rd1 = rep(24'd2); rd2 = rep(24'd3); in_valid = 1;
    tick();
    chk("mrst_busy", busy, 1);
    in_valid = 0; rst = 1;
    tick();
    rst = 0;
    chk("mrst_valid", out_valid, 0);
    chk("mrst_busy_clr", busy, 0);
    chk("mrst_ready", in_ready, 1);
    tick(); tick(); tick(); tick();
    chk("mrst_no_result", out_valid, 0);
    chk("mrst_result0", aluResult, '0);

    // reset beats a simultaneous accept
    aluControl = 4'd0; rd1 = rep(24'd5); rd2 = rep(24'd5); in_valid = 1; rst = 1;
    tick();
    rst = 0; in_valid = 0;
    chk("rst_accept_valid", out_valid, 0);
    chk("rst_accept_result", aluResult, '0);

    // signed overflow behaviour of ADD / SUB
    clear_ins();
    in_valid = 1; aluControl = 4'd0; rd1 = rep(24'h7FFFFF); rd2 = rep(24'd1);
    tick();
`ifdef ALU_EXEC_SAT_EN
    chk("ovf_add", aluResult, rep(24'h7FFFFF));
    chk("ovf_add_flags", flags, 8'h00);
`else
    chk("ovf_add", aluResult, rep(24'h800000));
    chk("ovf_add_flags", flags, 8'hAA);
`endif
    aluControl = 4'd1; rd1 = rep(24'h800000);
    tick();
`ifdef ALU_EXEC_SAT_EN
    chk("ovf_sub", aluResult, rep(24'h800000));
`else
    chk("ovf_sub", aluResult, rep(24'h7FFFFF));
`endif
    in_valid = 0;
    tick();
    chk("idle_valid", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
